mem_access: RTL and testbench
=============================

Name: mem_access

Overview:
- Load/store unit that consumes the execute stage's outputs: ALU result, memory address, load/store info, and rs2 data.
- Drives a request/grant/response data-memory bus. Aligns store data and byte strobes, and extracts and sign/zero-extends load data.
- Stalls the core while an access is in flight, then presents the memory-stage value for writeback.

Parameters:
WIDTH, 32, data/address width (only 32 supported)
TIMEOUT, 16, max cycles in WAIT before bus error (>=2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
exec_valid_i  input  1  execute-stage outputs valid this cycle
execute_valE_i  input  WIDTH  ALU result from execute
execute_mem_addr_i  input  WIDTH  effective address from execute
decode_load_store_info_i  input  8  one-hot: [0]LB [1]LH [2]LW [3]LBU [4]LHU [5]SB [6]SH [7]SW
decode_rs2_i  input  WIDTH  store data
dmem_req_o  output  1  bus request
dmem_we_o  output  1  1=write
dmem_addr_o  output  WIDTH  word-aligned address ({addr[31:2],2'b00})
dmem_wdata_o  output  WIDTH  lane-aligned write data
dmem_wstrb_o  output  4  byte strobes (0 on reads)
dmem_gnt_i  input  1  request accepted
dmem_rvalid_i  input  1  read data valid
dmem_rdata_i  input  WIDTH  read data word
memory_valM_o  output  WIDTH  writeback value
memory_done_o  output  1  valM valid pulse
memory_stall_o  output  1  hold pc/execute inputs
memory_misalign_o  output  1  misaligned access pulse
memory_bus_err_o  output  1  timeout pulse

Behaviour:
- Reset (async, rst_n=0): state=IDLE, timeout counter=0, latched regs=0.
- Reset outputs: dmem_req_o=0, dmem_we_o=0, dmem_wstrb_o=0, dmem_addr_o=0, dmem_wdata_o=0, memory_valM_o=0, all pulses 0.
- Reset mid-access drops dmem_req_o immediately. A later gnt/rvalid in IDLE is ignored.
- FSM states: IDLE, REQ, WAIT, DONE.
- IDLE, non-memory op (info==0) or exec_valid_i=0:
  - memory_valM_o = execute_valE_i, combinationally.
  - memory_done_o = exec_valid_i, memory_stall_o = 0.
- Misalignment: LH/LHU/SH with addr[0]=1, or LW/SW with addr[1:0]!=0.
  - In IDLE with exec_valid_i=1: memory_misalign_o=1 for that cycle.
  - No request, stall=0, done=0, stay IDLE.
- IDLE, valid aligned memory op:
  - memory_stall_o=1 combinationally.
  - Latch addr, info, formatted wdata/wstrb; next state REQ.
- Store formatting:
  - SB: wdata={4{rs2[7:0]}}, wstrb=4'b0001<<addr[1:0].
  - SH: wdata={2{rs2[15:0]}}, wstrb=4'b0011<<addr[1:0].
  - SW: wdata=rs2, wstrb=4'b1111.
- REQ:
  - dmem_req_o=1, stall=1; addr/we/wdata/wstrb stable until grant.
  - On gnt, store: next DONE.
  - On gnt, load: next WAIT, counter cleared. If rvalid_i is also high that cycle, capture data and go straight to DONE.
  - rvalid without gnt: ignored.
  - No timeout in REQ.
- WAIT:
  - stall=1, req=0; counter increments each cycle.
  - On rvalid: extract lane by addr[1:0] and register into valM.
    - LB/LBU: byte, sign/zero extended.
    - LH/LHU: half (addr[1] select), sign/zero extended.
    - LW: full word.
    - Next DONE.
  - Counter reaching TIMEOUT-1 without rvalid: memory_bus_err_o=1 for one cycle, valM unchanged, next IDLE. rvalid on that same cycle wins (DONE, no error).
- DONE:
  - memory_done_o=1 one cycle, stall=0 (core advances).
  - valM = loaded value, or execute_valE_i latched at start for stores. Next IDLE.
- Latency (core input must be held while stall=1):
  - Store: 3 cycles with immediate grant.
  - Load: 4 cycles with grant and rvalid one cycle apart.
- Outputs memory_valM_o, memory_done_o and memory_stall_o are combinational from state in IDLE and registered-data-driven otherwise. No combinational path from dmem_rdata_i to outputs.

Test Plan:
- LB at addr 0x1003, rdata=0x80FF_0000, gnt same cycle as req, rvalid next -> valM=0xFFFF_FF80, done at cycle 4, stall high cycles 1-3.
- LHU at 0x2002, rdata=0xBEEF_1234 -> valM=0x0000_BEEF. LH same data -> valM=0xFFFF_BEEF.
- SB addr 0x0001, rs2=0x1234_56AB -> wdata=0xABAB_ABAB, wstrb=4'b0010, dmem_addr_o=0x0000_0000, we=1, done with valM=valE.
- SW at 0x0006 -> misalign pulse 1 cycle, req never asserted, stall 0. ADD with valE=0x55 -> valM=0x55, done same cycle.
- LW with gnt held low 5 cycles, then rvalid never returns -> req stays high 5 cycles; bus_err pulses after TIMEOUT=16 WAIT cycles; FSM back to IDLE.
- Load in WAIT, rst_n driven low mid-access -> req/stall/done 0 asynchronously. rvalid after reset release ignored, valM=0.

Source files
------------

// File: rtl/mem_access_if.sv
// Data-memory request/grant/response bus between the load/store unit (master)
// and the data memory (slave).
interface mem_access_if #(
  parameter int WIDTH = 32
);
  logic             dmem_req_o;
  logic             dmem_we_o;
  logic [WIDTH-1:0] dmem_addr_o;
  logic [WIDTH-1:0] dmem_wdata_o;
  logic [3:0]       dmem_wstrb_o;
  logic             dmem_gnt_i;
  logic             dmem_rvalid_i;
  logic [WIDTH-1:0] dmem_rdata_i;

  modport master (
    output dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    input  dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );

  modport slave (
    input  dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o,
    output dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i
  );
endinterface

// File: rtl/mem_access.sv
// Load/store unit: formats stores, issues a req/gnt/rvalid bus access,
// extracts load lanes and stalls the core until the memory-stage value is ready.
module mem_access #(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             exec_valid_i,
  input  logic [WIDTH-1:0] execute_valE_i,
  input  logic [WIDTH-1:0] execute_mem_addr_i,
  input  logic [7:0]       decode_load_store_info_i,
  input  logic [WIDTH-1:0] decode_rs2_i,
  mem_access_if.master     dmem,
  output logic [WIDTH-1:0] memory_valM_o,
  output logic             memory_done_o,
  output logic             memory_stall_o,
  output logic             memory_misalign_o,
  output logic             memory_bus_err_o
);

  localparam int            CW       = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    DONE = 2'd3
  } state_e;

  function automatic logic [31:0] fmt_wdata(input logic sb, input logic sh,
                                            input logic [31:0] rs2);
    logic [31:0] w;
    if (sb) begin
      w = {4{rs2[7:0]}};
    end else if (sh) begin
      w = {2{rs2[15:0]}};
    end else begin
      w = rs2;
    end
    return w;
  endfunction

  function automatic logic [3:0] fmt_wstrb(input logic sb, input logic sh,
                                           input logic sw, input logic [1:0] off);
    logic [3:0] s;
    if (sb) begin
      s = 4'b0001 << off;
    end else if (sh) begin
      s = 4'b0011 << off;
    end else if (sw) begin
      s = 4'b1111;
    end else begin
      s = 4'b0000;
    end
    return s;
  endfunction

  // size: 0 = byte, 1 = half, 2 = word
  function automatic logic [31:0] load_extract(input logic sext, input logic [1:0] size,
                                               input logic [1:0] off, input logic [31:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] v;
    b = rdata[{off, 3'b000} +: 8];
    h = off[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      2'd0:    v = {{24{sext & b[7]}}, b};
      2'd1:    v = {{16{sext & h[15]}}, h};
      default: v = rdata;
    endcase
    return v;
  endfunction

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    addr_q, addr_d;
  logic [31:0]    wdata_q, wdata_d;
  logic [3:0]     wstrb_q, wstrb_d;
  logic           we_q, we_d;
  logic [1:0]     off_q, off_d;
  logic           sext_q, sext_d;
  logic [1:0]     size_q, size_d;
  logic [31:0]    valm_q, valm_d;

  logic ld_b_s, ld_h_s, ld_w_s, st_b_s, st_h_s, st_w_s;
  logic is_mem_s, is_store_s, misalign_s, accept_s;

  assign ld_b_s     = decode_load_store_info_i[0] | decode_load_store_info_i[3];
  assign ld_h_s     = decode_load_store_info_i[1] | decode_load_store_info_i[4];
  assign ld_w_s     = decode_load_store_info_i[2];
  assign st_b_s     = decode_load_store_info_i[5];
  assign st_h_s     = decode_load_store_info_i[6];
  assign st_w_s     = decode_load_store_info_i[7];
  assign is_mem_s   = |decode_load_store_info_i;
  assign is_store_s = st_b_s | st_h_s | st_w_s;
  assign misalign_s = ((ld_h_s | st_h_s) & execute_mem_addr_i[0]) |
                      ((ld_w_s | st_w_s) & (execute_mem_addr_i[1:0] != 2'b00));
  assign accept_s   = exec_valid_i & is_mem_s & ~misalign_s;

  // Next-state and latched-transaction computation.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wstrb_d = wstrb_q;
    we_d    = we_q;
    off_d   = off_q;
    sext_d  = sext_q;
    size_d  = size_q;
    valm_d  = valm_q;
    case (state_q)
      IDLE: begin
        if (accept_s) begin
          state_d = REQ;
          cnt_d   = '0;
          addr_d  = {execute_mem_addr_i[31:2], 2'b00};
          off_d   = execute_mem_addr_i[1:0];
          we_d    = is_store_s;
          wdata_d = is_store_s ? fmt_wdata(st_b_s, st_h_s, decode_rs2_i) : 32'h0000_0000;
          wstrb_d = fmt_wstrb(st_b_s, st_h_s, st_w_s, execute_mem_addr_i[1:0]);
          sext_d  = decode_load_store_info_i[0] | decode_load_store_info_i[1];
          size_d  = ld_b_s ? 2'd0 : (ld_h_s ? 2'd1 : 2'd2);
          valm_d  = execute_valE_i;
        end else begin
          state_d = IDLE;
        end
      end
      REQ: begin
        if (dmem.dmem_gnt_i) begin
          if (we_q) begin
            state_d = DONE;
          end else if (dmem.dmem_rvalid_i) begin
            valm_d  = load_extract(sext_q, size_q, off_q, dmem.dmem_rdata_i);
            state_d = DONE;
          end else begin
            cnt_d   = '0;
            state_d = WAIT;
          end
        end else begin
          state_d = REQ;
        end
      end
      WAIT: begin
        // A response on the last allowed cycle still beats the timeout.
        if (dmem.dmem_rvalid_i) begin
          valm_d  = load_extract(sext_q, size_q, off_q, dmem.dmem_rdata_i);
          state_d = DONE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and transaction registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= 32'h0000_0000;
      wdata_q <= 32'h0000_0000;
      wstrb_q <= 4'b0000;
      we_q    <= 1'b0;
      off_q   <= 2'b00;
      sext_q  <= 1'b0;
      size_q  <= 2'b00;
      valm_q  <= 32'h0000_0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wstrb_q <= wstrb_d;
      we_q    <= we_d;
      off_q   <= off_d;
      sext_q  <= sext_d;
      size_q  <= size_d;
      valm_q  <= valm_d;
    end
  end

  // Core-facing outputs: pass-through in IDLE, register-driven elsewhere.
  always_comb begin
    memory_valM_o     = valm_q;
    memory_done_o     = 1'b0;
    memory_stall_o    = 1'b0;
    memory_misalign_o = 1'b0;
    memory_bus_err_o  = 1'b0;
    case (state_q)
      IDLE: begin
        memory_valM_o = execute_valE_i;
        if (exec_valid_i & is_mem_s) begin
          if (misalign_s) begin
            memory_misalign_o = 1'b1;
          end else begin
            memory_stall_o = 1'b1;
          end
        end else begin
          memory_done_o = exec_valid_i;
        end
      end
      REQ: begin
        memory_stall_o = 1'b1;
      end
      WAIT: begin
        memory_stall_o   = 1'b1;
        memory_bus_err_o = (cnt_q == CNT_LAST) & ~dmem.dmem_rvalid_i;
      end
      DONE: begin
        memory_done_o = 1'b1;
      end
      default: begin
        memory_stall_o = 1'b0;
      end
    endcase
  end

  assign dmem.dmem_req_o   = (state_q == REQ);
  assign dmem.dmem_we_o    = we_q;
  assign dmem.dmem_addr_o  = addr_q;
  assign dmem.dmem_wdata_o = wdata_q;
  assign dmem.dmem_wstrb_o = wstrb_q;

endmodule

// File: tb/tb_mem_access.sv
// Self-checking bench for mem_access: directed scenarios plus randomized
// operations compared against a behavioural load/store model.
module tb_mem_access;

  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exec_valid;
  logic [31:0] vale, maddr, rs2;
  logic [7:0]  info;
  logic [31:0] valm_o;
  logic        done_o, stall_o, mis_o, berr_o;
  int          checks = 0;
  int          errors = 0;

  mem_access_if #(.WIDTH(32)) bus();

  mem_access #(.WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .exec_valid_i             (exec_valid),
    .execute_valE_i           (vale),
    .execute_mem_addr_i       (maddr),
    .decode_load_store_info_i (info),
    .decode_rs2_i             (rs2),
    .dmem                     (bus),
    .memory_valM_o            (valm_o),
    .memory_done_o            (done_o),
    .memory_stall_o           (stall_o),
    .memory_misalign_o        (mis_o),
    .memory_bus_err_o         (berr_o)
  );

  always #5 clk = ~clk;

  // Behavioural reference: lane shift, mask, optional sign fill.
  function automatic logic [31:0] ref_load(input int size, input bit sgn,
                                           input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] v, mask;
    v = rd >> ((a % 4) * 8);
    if (size == 4) return v;
    mask = (size == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
    v = v & mask;
    if (sgn && v[size*8-1]) v = v | ~mask;
    return v;
  endfunction

  function automatic logic [31:0] ref_wdata(input int size, input logic [31:0] d);
    logic [31:0] w;
    w = 32'h0;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = d[8*(i % size) +: 8];
    return w;
  endfunction

  function automatic logic [3:0] ref_wstrb(input int size, input logic [31:0] a);
    logic [3:0] s;
    int off;
    off = a % 4;
    s = 4'b0000;
    for (int i = 0; i < 4; i++) s[i] = (i >= off) && (i < off + size);
    return s;
  endfunction

  // Drives one operation and acts as memory; returns observations only.
  task automatic run_op(input logic [7:0] inf, input logic [31:0] a, input logic [31:0] d,
                        input logic [31:0] ve, input logic [31:0] rd,
                        input int gnt_wait, input int rv_wait,
                        output int done_cyc, output logic [31:0] valm_obs, output int req_cnt,
                        output logic [31:0] baddr, output logic [31:0] bwdata,
                        output logic [3:0] bwstrb, output logic bwe, output logic unstable,
                        output logic [63:0] stall_mask, output int err_cyc, output int mis_cyc);
    int gnt_cyc;
    done_cyc = 0; valm_obs = 32'h0; req_cnt = 0; baddr = 32'h0; bwdata = 32'h0;
    bwstrb = 4'h0; bwe = 1'b0; unstable = 1'b0; stall_mask = 64'h0;
    err_cyc = 0; mis_cyc = 0; gnt_cyc = -1;
    exec_valid = 1'b1; info = inf; maddr = a; rs2 = d; vale = ve;
    bus.dmem_rdata_i = rd;
    for (int c = 1; c <= 60; c++) begin
      bus.dmem_gnt_i = 1'b0;
      bus.dmem_rvalid_i = 1'b0;
      if (bus.dmem_req_o) begin
        if (req_cnt == 0) begin
          baddr = bus.dmem_addr_o; bwdata = bus.dmem_wdata_o;
          bwstrb = bus.dmem_wstrb_o; bwe = bus.dmem_we_o;
        end else if (baddr !== bus.dmem_addr_o || bwdata !== bus.dmem_wdata_o ||
                     bwstrb !== bus.dmem_wstrb_o || bwe !== bus.dmem_we_o) begin
          unstable = 1'b1;
        end
        if (req_cnt >= gnt_wait) begin
          bus.dmem_gnt_i = 1'b1;
          gnt_cyc = c;
        end
        req_cnt++;
      end
      if (gnt_cyc >= 0 && rv_wait >= 0 && c - gnt_cyc == rv_wait) bus.dmem_rvalid_i = 1'b1;
      #1;
      if (stall_o) stall_mask[c] = 1'b1;
      if (done_o && done_cyc == 0) begin
        done_cyc = c;
        valm_obs = valm_o;
      end
      if (berr_o) err_cyc = c;
      if (mis_o) mis_cyc = c;
      if (done_o || berr_o || mis_o) break;
      @(posedge clk);
      @(negedge clk);
    end
    exec_valid = 1'b0; info = 8'h00;
    bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  int          r_done, r_req, r_err, r_mis;
  logic [31:0] r_valm, r_addr, r_wdata;
  logic [3:0]  r_wstrb;
  logic        r_we, r_unst;
  logic [63:0] r_stall;

  task automatic test_reset();
    rst_n = 1'b0; exec_valid = 1'b0; info = 8'h00; maddr = 32'h0; rs2 = 32'h0; vale = 32'h0;
    bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.dmem_req_o, bus.dmem_we_o, bus.dmem_wstrb_o} !== 6'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 000000",
                         {bus.dmem_req_o, bus.dmem_we_o, bus.dmem_wstrb_o});
    end
    checks++;
    if (bus.dmem_addr_o !== 32'h0 || bus.dmem_wdata_o !== 32'h0 || valm_o !== 32'h0) begin
      errors++; $display("FAIL reset_data: got addr=%h wdata=%h valm=%h expected all 0",
                         bus.dmem_addr_o, bus.dmem_wdata_o, valm_o);
    end
    checks++;
    if ({done_o, stall_o, mis_o, berr_o} !== 4'b0) begin
      errors++; $display("FAIL reset_pulses: got %b expected 0000", {done_o, stall_o, mis_o, berr_o});
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_lb();
    run_op(8'h01, 32'h0000_1003, 32'h0, 32'h0, 32'h80FF_0000, 0, 1,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_valm !== 32'hFFFF_FF80) begin errors++; $display("FAIL lb_valm: got %h expected ffffff80", r_valm); end
    checks++;
    if (r_done !== 4) begin errors++; $display("FAIL lb_done_cycle: got %0d expected 4", r_done); end
    checks++;
    if (r_stall !== 64'hE) begin errors++; $display("FAIL lb_stall: got %h expected e", r_stall); end
    checks++;
    if (r_addr !== 32'h0000_1000 || r_wstrb !== 4'h0 || r_we !== 1'b0) begin
      errors++; $display("FAIL lb_bus: got addr=%h wstrb=%b we=%b expected 00001000/0000/0", r_addr, r_wstrb, r_we);
    end
  endtask

  task automatic test_lh();
    run_op(8'h10, 32'h0000_2002, 32'h0, 32'h0, 32'hBEEF_1234, 0, 1,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_valm !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu_valm: got %h expected 0000beef", r_valm); end
    run_op(8'h02, 32'h0000_2002, 32'h0, 32'h0, 32'hBEEF_1234, 1, 2,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_valm !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh_valm: got %h expected ffffbeef", r_valm); end
    checks++;
    if (r_req !== 2 || r_done !== 6) begin
      errors++; $display("FAIL lh_latency: got req=%0d done=%0d expected 2/6", r_req, r_done);
    end
  endtask

  task automatic test_store_sb();
    run_op(8'h20, 32'h0000_0001, 32'h1234_56AB, 32'hCAFE_0001, 32'h0, 0, -1,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_wdata !== 32'hABAB_ABAB || r_wstrb !== 4'b0010) begin
      errors++; $display("FAIL sb_format: got wdata=%h wstrb=%b expected ababab ab/0010", r_wdata, r_wstrb);
    end
    checks++;
    if (r_addr !== 32'h0 || r_we !== 1'b1) begin
      errors++; $display("FAIL sb_bus: got addr=%h we=%b expected 0/1", r_addr, r_we);
    end
    checks++;
    if (r_done !== 3 || r_valm !== 32'hCAFE_0001) begin
      errors++; $display("FAIL sb_done: got cycle=%0d valm=%h expected 3/cafe0001", r_done, r_valm);
    end
  endtask

  task automatic test_misalign_and_alu();
    run_op(8'h80, 32'h0000_0006, 32'h1, 32'h2, 32'h0, 0, -1,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_mis !== 1 || r_req !== 0 || r_stall !== 64'h0 || r_done !== 0) begin
      errors++; $display("FAIL sw_misalign: got mis=%0d req=%0d stall=%h done=%0d expected 1/0/0/0",
                         r_mis, r_req, r_stall, r_done);
    end
    checks++;
    if (mis_o !== 1'b0) begin errors++; $display("FAIL misalign_pulse_width: got %b expected 0", mis_o); end
    run_op(8'h00, 32'h0000_0006, 32'h0, 32'h0000_0055, 32'h0, 0, -1,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_done !== 1 || r_valm !== 32'h55 || r_stall !== 64'h0) begin
      errors++; $display("FAIL alu_passthru: got done=%0d valm=%h stall=%h expected 1/55/0", r_done, r_valm, r_stall);
    end
    vale = 32'h0000_1234;
    #1;
    checks++;
    if (done_o !== 1'b0 || valm_o !== 32'h0000_1234) begin
      errors++; $display("FAIL idle_invalid: got done=%b valm=%h expected 0/00001234", done_o, valm_o);
    end
    vale = 32'h0;
    @(negedge clk);
  endtask

  task automatic test_timeout();
    run_op(8'h04, 32'h0000_0100, 32'h0, 32'h0, 32'h0, 4, -1,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_req !== 5 || r_unst !== 1'b0) begin
      errors++; $display("FAIL timeout_req: got req=%0d unstable=%b expected 5/0", r_req, r_unst);
    end
    checks++;
    if (r_err !== 2 + 4 + TIMEOUT || r_done !== 0) begin
      errors++; $display("FAIL timeout_err_cycle: got err=%0d done=%0d expected %0d/0", r_err, r_done, 2 + 4 + TIMEOUT);
    end
    checks++;
    if (r_stall !== (((64'd1 << (2 + 4 + TIMEOUT + 1)) - 64'd1) & ~64'd1)) begin
      errors++; $display("FAIL timeout_stall: got %h", r_stall);
    end
    checks++;
    if (berr_o !== 1'b0 || stall_o !== 1'b0 || bus.dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: got err=%b stall=%b req=%b expected 000", berr_o, stall_o, bus.dmem_req_o);
    end
  endtask

  task automatic test_rvalid_boundary();
    run_op(8'h04, 32'h0000_0200, 32'h0, 32'h0, 32'h1357_9BDF, 0, TIMEOUT,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_err !== 0 || r_done !== 2 + TIMEOUT + 1 || r_valm !== 32'h1357_9BDF) begin
      errors++; $display("FAIL rvalid_last_cycle: got err=%0d done=%0d valm=%h expected 0/%0d/13579bdf",
                         r_err, r_done, r_valm, 2 + TIMEOUT + 1);
    end
    run_op(8'h08, 32'h0000_0302, 32'h0, 32'h0, 32'h00A5_0000, 0, 0,
           r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
    checks++;
    if (r_done !== 3 || r_valm !== 32'h0000_00A5) begin
      errors++; $display("FAIL rvalid_with_gnt: got done=%0d valm=%h expected 3/000000a5", r_done, r_valm);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      int k, size, gw, rv, exp_done;
      bit store, sgn, mal;
      logic [7:0] inf;
      logic [31:0] a, d, ve, rd, exp_val;
      k = $urandom_range(8, 0);
      inf = (k < 8) ? (8'd1 << k) : 8'd0;
      size = (k == 0 || k == 3 || k == 5) ? 1 : ((k == 1 || k == 4 || k == 6) ? 2 : 4);
      store = (k >= 5 && k <= 7);
      sgn = (k == 0 || k == 1);
      a = $urandom;
      if ($urandom_range(3, 0) != 0) a = a - (a % size);
      d = $urandom; ve = $urandom; rd = $urandom;
      gw = $urandom_range(3, 0); rv = $urandom_range(4, 0);
      mal = (k < 8) && (a % size != 0);
      run_op(inf, a, d, ve, rd, gw, store ? -1 : rv,
             r_done, r_valm, r_req, r_addr, r_wdata, r_wstrb, r_we, r_unst, r_stall, r_err, r_mis);
      if (k == 8) begin
        checks++;
        if (r_done !== 1 || r_valm !== ve || r_req !== 0) begin
          errors++; $display("FAIL rnd_alu[%0d]: got done=%0d valm=%h expected 1/%h", n, r_done, r_valm, ve);
        end
      end else if (mal) begin
        checks++;
        if (r_mis !== 1 || r_req !== 0 || r_done !== 0 || r_stall !== 64'h0) begin
          errors++; $display("FAIL rnd_misalign[%0d]: got mis=%0d req=%0d done=%0d", n, r_mis, r_req, r_done);
        end
      end else begin
        exp_done = 2 + gw + (store ? 0 : rv) + 1;
        exp_val  = store ? ve : ref_load(size, sgn, a, rd);
        checks++;
        if (r_done !== exp_done || r_valm !== exp_val || r_err !== 0) begin
          errors++; $display("FAIL rnd_result[%0d] info=%h: got done=%0d valm=%h err=%0d expected %0d/%h/0",
                             n, inf, r_done, r_valm, r_err, exp_done, exp_val);
        end
        checks++;
        if (r_stall !== (((64'd1 << exp_done) - 64'd1) & ~64'd1) || r_req !== gw + 1 || r_unst !== 1'b0) begin
          errors++; $display("FAIL rnd_handshake[%0d]: got stall=%h req=%0d unstable=%b expected req=%0d",
                             n, r_stall, r_req, r_unst, gw + 1);
        end
        checks++;
        if (r_addr !== (a & 32'hFFFF_FFFC) || r_we !== store ||
            r_wstrb !== (store ? ref_wstrb(size, a) : 4'b0000) ||
            (store && r_wdata !== ref_wdata(size, d))) begin
          errors++; $display("FAIL rnd_bus[%0d] info=%h: got addr=%h we=%b wstrb=%b wdata=%h", n, inf,
                             r_addr, r_we, r_wstrb, r_wdata);
        end
      end
    end
  endtask

  task automatic test_reset_mid_access();
    exec_valid = 1'b1; info = 8'h04; maddr = 32'h0000_0040; vale = 32'h0;
    @(negedge clk);
    bus.dmem_gnt_i = 1'b1;
    @(negedge clk);
    bus.dmem_gnt_i = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (stall_o !== 1'b1) begin errors++; $display("FAIL mid_wait_stall: got %b expected 1", stall_o); end
    #2;
    rst_n = 1'b0; exec_valid = 1'b0; info = 8'h00;
    #1;
    checks++;
    if ({bus.dmem_req_o, stall_o, done_o} !== 3'b000) begin
      errors++; $display("FAIL mid_reset: got req/stall/done=%b expected 000", {bus.dmem_req_o, stall_o, done_o});
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = 32'hDEAD_BEEF;
    #1;
    checks++;
    if (done_o !== 1'b0 || valm_o !== 32'h0 || stall_o !== 1'b0) begin
      errors++; $display("FAIL stray_rvalid: got done=%b valm=%h stall=%b expected 0/0/0", done_o, valm_o, stall_o);
    end
    @(negedge clk);
    bus.dmem_rvalid_i = 1'b0;
    #1;
    checks++;
    if (done_o !== 1'b0 || valm_o !== 32'h0 || bus.dmem_req_o !== 1'b0) begin
      errors++; $display("FAIL after_stray: got done=%b valm=%h req=%b expected 0/0/0", done_o, valm_o, bus.dmem_req_o);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_lb();
    test_lh();
    test_store_sb();
    test_misalign_and_alu();
    test_timeout();
    test_rvalid_boundary();
    test_random();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
